// File: rtl/minimax_ai.sv
// Connect-Four move selector: scores each legal column one per cycle against a board snapshot
// and registers the drop cell's MSB bit index once all seven candidates have been visited.
module minimax_ai (
  input  logic        clk,
  input  logic        rst,
  input  logic [83:0] grid,
  input  logic [20:0] column_counts,
  input  logic        player,
  input  logic        sw,
  output logic [6:0]  opt,
  output logic        move
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  localparam logic [1:0] CellHuman = 2'b01;
  localparam logic [1:0] CellAi    = 2'b10;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  best_score_q, best_score_d;
  logic [6:0]  best_idx_q, best_idx_d;
  logic [83:0] grid_snap_q, grid_snap_d;
  logic [20:0] counts_snap_q, counts_snap_d;
  logic [6:0]  opt_q, opt_d;
  logic        move_q, move_d;

  // Owner of a cell; off-board cells and code 11 read as empty.
  function automatic logic [1:0] owner_at(input logic [83:0] g, input int c, input int r);
    logic [6:0] idx;
    logic [1:0] code;
    owner_at = 2'b00;
    if (c >= 0 && c <= 6 && r >= 0 && r <= 5) begin
      idx  = 7'(12 - 2 * c + 14 * r);
      code = g[idx +: 2];
      owner_at = (code == 2'b11) ? 2'b00 : code;
    end
  endfunction

  // True if a piece of owner p dropped at (c,r) completes a line of four or more.
  function automatic logic makes_four(input logic [83:0] g, input int c, input int r,
                                      input logic [1:0] p);
    int   dx, dy, cnt;
    logic run;
    makes_four = 1'b0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dx = 1; dy = 0;  end
        1:       begin dx = 0; dy = 1;  end
        2:       begin dx = 1; dy = 1;  end
        default: begin dx = 1; dy = -1; end
      endcase
      cnt = 1;
      run = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        if (run && owner_at(g, c + s * dx, r + s * dy) == p) cnt++;
        else run = 1'b0;
      end
      run = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        if (run && owner_at(g, c - s * dx, r - s * dy) == p) cnt++;
        else run = 1'b0;
      end
      if (cnt >= 4) makes_four = 1'b1;
    end
  endfunction

  int         cand_col;
  logic [4:0] cand_base;
  logic [2:0] cand_n;
  logic [6:0] cand_idx;
  logic [1:0] cand_score;
  logic [1:0] upd_score;
  logic [6:0] upd_idx;

  // Centre-first visiting order so that score ties keep the most central column.
  always_comb begin
    cand_col = 6;
    unique case (k_q)
      3'd0:    cand_col = 3;
      3'd1:    cand_col = 2;
      3'd2:    cand_col = 4;
      3'd3:    cand_col = 1;
      3'd4:    cand_col = 5;
      3'd5:    cand_col = 0;
      default: cand_col = 6;
    endcase
    cand_base = 5'(3 * cand_col);
    cand_n    = counts_snap_q[cand_base +: 3];
    cand_idx  = 7'(13 - 2 * cand_col + 14 * int'(cand_n));
    if (cand_n >= 3'd6) begin
      cand_score = 2'd0;
    end else if (makes_four(grid_snap_q, cand_col, int'(cand_n), CellAi)) begin
      cand_score = 2'd3;
    end else if (makes_four(grid_snap_q, cand_col, int'(cand_n), CellHuman)) begin
      cand_score = 2'd2;
    end else begin
      cand_score = 2'd1;
    end
    if (cand_score > best_score_q) begin
      upd_score = cand_score;
      upd_idx   = cand_idx;
    end else begin
      upd_score = best_score_q;
      upd_idx   = best_idx_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    grid_snap_d   = grid_snap_q;
    counts_snap_d = counts_snap_q;
    opt_d         = opt_q;
    move_d        = move_q;
    unique case (state_q)
      StIdle: begin
        move_d = 1'b0;
        if (sw && player) begin
          grid_snap_d   = grid;
          counts_snap_d = column_counts;
          best_score_d  = 2'd0;
          best_idx_d    = 7'd0;
          k_d           = 3'd0;
          state_d       = StEval;
        end
      end
      StEval: begin
        if (!sw || !player) begin
          move_d  = 1'b0;
          state_d = StIdle;
        end else begin
          best_score_d = upd_score;
          best_idx_d   = upd_idx;
          if (k_q == 3'd6) begin
            // A zero best score means every column is full: no move to offer.
            opt_d   = (upd_score != 2'd0) ? upd_idx : 7'd0;
            move_d  = (upd_score != 2'd0);
            state_d = StDone;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      StDone: begin
        if (!player || !sw || grid != grid_snap_q || column_counts != counts_snap_q) begin
          move_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        move_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      k_q           <= 3'd0;
      best_score_q  <= 2'd0;
      best_idx_q    <= 7'd0;
      grid_snap_q   <= 84'd0;
      counts_snap_q <= 21'd0;
      opt_q         <= 7'd0;
      move_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      grid_snap_q   <= grid_snap_d;
      counts_snap_q <= counts_snap_d;
      opt_q         <= opt_d;
      move_q        <= move_d;
    end
  end

  assign opt  = opt_q;
  assign move = move_q;

endmodule

// File: tb/tb_minimax_ai.sv
// Directed-vector bench for minimax_ai: hand-built boards with hand-computed drop cells.
module tb_minimax_ai;

  logic        clk = 1'b0;
  logic        rst;
  logic [83:0] grid;
  logic [20:0] column_counts;
  logic        player;
  logic        sw;
  logic [6:0]  opt;
  logic        move;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  minimax_ai dut (
    .clk           (clk),
    .rst           (rst),
    .grid          (grid),
    .column_counts (column_counts),
    .player        (player),
    .sw            (sw),
    .opt           (opt),
    .move          (move)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [83:0] put(input logic [83:0] g, input int c, input int r,
                                      input logic [1:0] code);
    logic [83:0] t;
    t = g;
    t[12 - 2 * c + 14 * r +: 2] = code;
    return t;
  endfunction

  function automatic logic [20:0] cnt(input logic [20:0] cc, input int c, input logic [2:0] n);
    logic [20:0] t;
    t = cc;
    t[3 * c +: 3] = n;
    return t;
  endfunction

  // Leave DONE, load a board, raise player: the next edge is the start edge.
  task automatic start_eval(input logic [83:0] g, input logic [20:0] cc);
    player = 1'b0;
    tick;
    tick;
    grid          = g;
    column_counts = cc;
    player        = 1'b1;
  endtask

  task automatic wait_move(input int budget);
    for (int i = 0; i < budget && move !== 1'b1; i++) tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = 1'b1; player = 1'b0; grid = '0; column_counts = '0;
    tick;
    tick;
    rst = 1'b0;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL reset_move: got %0b want 0", move); end
    nvec++;
    if (opt !== 7'd0) begin nerr++; $display("FAIL reset_opt: got %0d want 0", opt); end
  endtask

  task automatic test_empty_latency;
    start_eval('0, '0);
    tick;
    repeat (6) tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL empty_early: move=%0b want 0", move); end
    tick;
    nvec++;
    if (move !== 1'b1) begin nerr++; $display("FAIL empty_move: move=%0b want 1", move); end
    nvec++;
    if (opt !== 7'd7) begin nerr++; $display("FAIL empty_opt: got %0d want 7", opt); end
  endtask

  task automatic test_ai_win;
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 3; r++) g = put(g, 0, r, 2'b10);
    start_eval(g, cnt('0, 0, 3'd3));
    wait_move(20);
    nvec++;
    if (move !== 1'b1) begin nerr++; $display("FAIL ai_win_move: move=%0b want 1", move); end
    nvec++;
    if (opt !== 7'd55) begin nerr++; $display("FAIL ai_win_opt: got %0d want 55", opt); end
  endtask

  task automatic test_block_vertical;
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 3; r++) g = put(g, 6, r, 2'b01);
    start_eval(g, cnt('0, 6, 3'd3));
    wait_move(20);
    nvec++;
    if (opt !== 7'd43 || move !== 1'b1) begin
      nerr++; $display("FAIL block_vert: opt=%0d move=%0b want 43/1", opt, move);
    end
  endtask

  task automatic test_block_horizontal;
    logic [83:0] g;
    logic [20:0] cc;
    g  = '0;
    cc = '0;
    for (int c = 1; c <= 3; c++) begin
      g  = put(g, c, 0, 2'b01);
      cc = cnt(cc, c, 3'd1);
    end
    start_eval(g, cc);
    wait_move(20);
    nvec++;
    if (opt !== 7'd5 || move !== 1'b1) begin
      nerr++; $display("FAIL block_horiz: opt=%0d move=%0b want 5/1", opt, move);
    end
  endtask

  task automatic test_diagonal;
    logic [83:0] g;
    logic [20:0] cc;
    g = '0;
    g = put(g, 0, 0, 2'b01); g = put(g, 0, 1, 2'b10); g = put(g, 0, 2, 2'b01);
    g = put(g, 1, 0, 2'b01); g = put(g, 1, 1, 2'b01); g = put(g, 1, 2, 2'b10);
    g = put(g, 2, 0, 2'b01); g = put(g, 2, 1, 2'b10);
    g = put(g, 3, 0, 2'b10);
    cc = cnt(cnt(cnt(cnt('0, 0, 3'd3), 1, 3'd3), 2, 3'd2), 3, 3'd1);
    start_eval(g, cc);
    wait_move(20);
    nvec++;
    if (opt !== 7'd55 || move !== 1'b1) begin
      nerr++; $display("FAIL diag_win: opt=%0d move=%0b want 55/1", opt, move);
    end
  endtask

  task automatic test_full_column;
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 6; r++) g = put(g, 3, r, (r % 2 == 0) ? 2'b10 : 2'b01);
    start_eval(g, cnt('0, 3, 3'd6));
    wait_move(20);
    nvec++;
    if (opt !== 7'd9 || move !== 1'b1) begin
      nerr++; $display("FAIL full_col: opt=%0d move=%0b want 9/1", opt, move);
    end
  endtask

  task automatic test_full_board;
    logic [20:0] cc;
    cc = '0;
    for (int c = 0; c < 7; c++) cc = cnt(cc, c, 3'd6);
    start_eval('0, cc);
    repeat (12) tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL full_board_move: got %0b want 0", move); end
    nvec++;
    if (opt !== 7'd0) begin nerr++; $display("FAIL full_board_opt: got %0d want 0", opt); end
  endtask

  task automatic test_invalidation;
    logic [83:0] g;
    logic [20:0] cc;
    g = '0;
    for (int r = 0; r < 3; r++) g = put(g, 0, r, 2'b10);
    cc = cnt('0, 0, 3'd3);
    start_eval(g, cc);
    wait_move(20);
    nvec++;
    if (move !== 1'b1) begin nerr++; $display("FAIL inval_setup: move=%0b want 1", move); end
    grid = put(g, 5, 0, 2'b01);
    tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL inval_grid: move=%0b want 0", move); end
    repeat (7) tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL reeval_early: move=%0b want 0", move); end
    tick;
    nvec++;
    if (move !== 1'b1 || opt !== 7'd55) begin
      nerr++; $display("FAIL reeval: opt=%0d move=%0b want 55/1", opt, move);
    end
    column_counts = cnt(cc, 4, 3'd1);
    tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL inval_counts: move=%0b want 0", move); end
    wait_move(20);
    player = 1'b0;
    tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL inval_player: move=%0b want 0", move); end
  endtask

  task automatic test_disable_abort;
    int seen;
    sw = 1'b0;
    start_eval('0, '0);
    seen = 0;
    repeat (12) begin
      tick;
      if (move === 1'b1) seen++;
    end
    nvec++;
    if (seen !== 0) begin nerr++; $display("FAIL disabled: move cycles=%0d want 0", seen); end
    sw = 1'b1;
    tick;
    repeat (3) tick;
    sw = 1'b0;
    seen = 0;
    repeat (10) begin
      tick;
      if (move === 1'b1) seen++;
    end
    nvec++;
    if (seen !== 0) begin nerr++; $display("FAIL abort_eval: move cycles=%0d want 0", seen); end
    sw = 1'b1;
    repeat (8) tick;
    nvec++;
    if (move !== 1'b1 || opt !== 7'd7) begin
      nerr++; $display("FAIL resume: opt=%0d move=%0b want 7/1", opt, move);
    end
  endtask

  task automatic test_reset_mid_eval;
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 3; r++) g = put(g, 6, r, 2'b01);
    start_eval(g, cnt('0, 6, 3'd3));
    tick;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    nvec++;
    if (move !== 1'b0 || opt !== 7'd0) begin
      nerr++; $display("FAIL reset_eval: opt=%0d move=%0b want 0/0", opt, move);
    end
    rst = 1'b0;
    repeat (7) tick;
    nvec++;
    if (move !== 1'b0) begin nerr++; $display("FAIL post_reset_early: move=%0b want 0", move); end
    tick;
    nvec++;
    if (move !== 1'b1 || opt !== 7'd43) begin
      nerr++; $display("FAIL post_reset: opt=%0d move=%0b want 43/1", opt, move);
    end
  endtask

  initial begin
    test_reset;
    test_empty_latency;
    test_ai_win;
    test_block_vertical;
    test_block_horizontal;
    test_diagonal;
    test_full_column;
    test_full_board;
    test_invalidation;
    test_disable_abort;
    test_reset_mid_eval;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/minimax_ai.md
# minimax_ai

Connect-Four move selector for the computer opponent. It samples the 6×7 board and per-column fill counts from the game-control block. When it is the AI's turn in AI mode, it scores every legal column sequentially and presents the chosen drop cell as a grid bit index with a valid flag. The controller writes `2'b10` at `grid[opt -: 2]` when `move` is high.

## Interface
Parameters: none.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `grid` input 84: board.
  - Cell (column c 0..6, row r 0..5, row 0 = bottom) occupies bits [13−2c+14r : 12−2c+14r].
  - Cell codes: 00 empty, 01 human, 10 AI, 11 treated as empty.
- `column_counts` input 21: pieces in column c at bits [3c+2:3c]. Values 0..6; a value ≥6 means the column is full.
- `player` input 1: 1 = AI to move.
- `sw` input 1: 1 = AI mode enabled.
- `opt` output 7: MSB bit index of the chosen cell, 13−2c+14·column_counts[c]. Range 1..83.
- `move` output 1: `opt` is valid for the current board.

## Operation
The state machine has three states: IDLE, EVAL, DONE.

- **IDLE**
  - `move`=0.
  - When `sw`=1 and `player`=1: snapshot `grid` and `column_counts`, clear best score, set index k=0, go to EVAL.
- **EVAL**
  - One candidate per cycle, visiting columns in the fixed order 3,2,4,1,5,0,6 (k=0..6).
  - For candidate column c with n=count[c]:
    - If n≥6: score 0 (illegal).
    - Otherwise place a hypothetical piece at (c,n) in the snapshot:
      - 3 if an AI piece there gives four-in-a-row.
      - 2 if a human piece there gives four-in-a-row.
      - 1 otherwise.
  - Four-in-a-row check: count contiguous same-owner cells through (c,n) in four lines (horizontal, vertical, both diagonals), including (c,n). Win if any line reaches ≥4. Ignore cells off the board.
  - Replace the best result only if the score is strictly greater. Ties therefore favour centre-first order.
  - Candidate cell index = 13−2c+14n, computed in 7-bit unsigned.
  - After k=6:
    - Best score >0: register `opt`, set `move`=1, go to DONE.
    - Best score 0 (board full): `opt`=0, `move`=0, go to DONE.
- **DONE**
  - Hold `opt` and `move`.
  - Go to IDLE, with `move` cleared on the same edge, if any of these hold:
    - `player`=0
    - `sw`=0
    - `grid` ≠ snapshot
    - `column_counts` ≠ snapshot
  - This prevents a stale `opt` from being used after any board change.
- **Abort in EVAL**: if `sw` or `player` drops during EVAL, return to IDLE with no result.
- **Input stability**: inputs are only sampled into the snapshot. Input changes during EVAL are caught by the DONE comparison.

## Timing
- Reset (synchronous): state IDLE, `opt`=0, `move`=0, snapshot cleared. Reset mid-EVAL aborts evaluation; `move` stays 0.
- Latency:
  - Start condition sampled at edge S.
  - Candidates evaluated at edges S+1..S+7.
  - `move`=1 is visible after edge S+7 and is registered.
- `move` falls on the first edge at which a DONE exit condition is sampled.
- A new evaluation may start on the edge after returning to IDLE.
- Outputs are registered; there is no combinational path from inputs to `opt`/`move`.

## Test plan
- **Empty board**: grid=0, counts=0, `sw`=1, `player`=1 → `move` rises after 8 cycles, `opt`=7 (column 3, row 0).
- **AI win**: AI pieces at column 0 rows 0..2, count0=3, others 0 → `opt`=55 (win outranks centre).
- **Block**: human pieces at column 6 rows 0..2, count6=3, no AI threat → `opt`=43.
- **Full column / full board**:
  - Column 3 full (count=6) with a non-threatening alternating pattern → `opt`=9 (column 2).
  - All counts=6 → `move` stays 0.
- **Invalidation**: in DONE, change one grid cell or drop `player` → `move`=0 on the next edge. With `player` still 1, re-evaluation gives `move`=1 again 8 cycles later.
- **Disable and reset**:
  - `sw`=0 with `player`=1 → `move` never asserts.
  - Assert `rst` during EVAL → `move`=0, `opt`=0, state IDLE.
